// File: rtl/terrain_probe_scheduler_if.sv
// Single shared map-memory read port: the scheduler drives address/enable,
// the map returns a 2-bit terrain code a fixed number of cycles later.
interface terrain_probe_scheduler_if;
  logic [15:0] map_addr;
  logic        map_en;
  logic [1:0]  map_data;

  modport master (output map_addr, output map_en, input map_data);
  modport slave  (input map_addr, input map_en, output map_data);
endinterface

// File: rtl/terrain_probe_scheduler.sv
// Sweeps five terrain probes (center, +x, +y, -x, -y) around a ball position
// through one pipelined map-memory port and publishes all five codes at once.
module terrain_probe_scheduler #(
  parameter int          WIDTH        = 160,
  parameter int          HEIGHT       = 90,
  parameter logic [15:0] PROBE_OFFSET = 16'h0080,
  parameter int          READ_LATENCY = 2
) (
  input  logic                             clk_in,
  input  logic                             rst_in_n,
  input  logic                             start,
  input  logic [15:0]                      ball_position_x,
  input  logic [15:0]                      ball_position_y,
  terrain_probe_scheduler_if.master        map,
  output logic [1:0]                       terrain_center,
  output logic [1:0]                       terrain_xplus,
  output logic [1:0]                       terrain_yplus,
  output logic [1:0]                       terrain_xminus,
  output logic [1:0]                       terrain_yminus,
  output logic                             busy,
  output logic                             done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [3:0] LAST_ISSUE = 4'd4;
  localparam logic [3:0] LAST_DRAIN = 4'(4 + READ_LATENCY);

  state_t          state, state_next;
  logic [3:0]      cyc;
  logic [15:0]     pos_x, pos_y;
  logic [4:0]      probe_oor_q;
  logic [4:0][1:0] stage, stage_next, result;
  logic [8:0]      probe_x_hi, probe_y_hi;
  logic            probe_oor;
  logic [15:0]     probe_addr;

  // State register
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   if (cyc == LAST_ISSUE) state_next = DRAIN;
      DRAIN:   if (cyc == LAST_DRAIN) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    done         = (state == DONE);
    map.map_en   = 1'b0;
    map.map_addr = '0;
    if (state == ISSUE && !probe_oor) begin
      map.map_en   = 1'b1;
      map.map_addr = probe_addr;
    end
  end

  // Pixel coordinate of the probe issued this cycle; bit 8 is the 17-bit carry/borrow.
  always_comb begin
    probe_x_hi = {1'b0, pos_x[15:8]};
    probe_y_hi = {1'b0, pos_y[15:8]};
    case (cyc)
      4'd1:    probe_x_hi = 9'(({1'b0, pos_x} + {1'b0, PROBE_OFFSET}) >> 8);
      4'd2:    probe_y_hi = 9'(({1'b0, pos_y} + {1'b0, PROBE_OFFSET}) >> 8);
      4'd3:    probe_x_hi = 9'(({1'b0, pos_x} - {1'b0, PROBE_OFFSET}) >> 8);
      4'd4:    probe_y_hi = 9'(({1'b0, pos_y} - {1'b0, PROBE_OFFSET}) >> 8);
      default: ;
    endcase
    probe_oor  = probe_x_hi[8] | probe_y_hi[8]
               | (32'(probe_x_hi[7:0]) >= WIDTH)
               | (32'(probe_y_hi[7:0]) >= HEIGHT);
    probe_addr = 16'(probe_x_hi[7:0]) + 16'(WIDTH) * 16'(probe_y_hi[7:0]);
  end

  // Probe k's data arrives READ_LATENCY cycles after its issue cycle.
  always_comb begin
    stage_next = stage;
    for (int k = 0; k < 5; k++) begin
      if ((state == ISSUE || state == DRAIN) && cyc == 4'(k + READ_LATENCY))
        stage_next[k] = probe_oor_q[k] ? 2'd1 : map.map_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      // NOTE: staging and result registers are a handful of flops, so they are
      // reset explicitly; a reset-mid-sweep must leave every code reading 0.
      pos_x       <= '0;
      pos_y       <= '0;
      cyc         <= '0;
      probe_oor_q <= '0;
      stage       <= '0;
      result      <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      if (state == IDLE && start) begin
        pos_x <= ball_position_x;
        pos_y <= ball_position_y;
      end
      cyc   <= (state == ISSUE || state == DRAIN) ? cyc + 4'd1 : 4'd0;
      stage <= stage_next;
      for (int k = 0; k < 5; k++) begin
        if (state == ISSUE && cyc == 4'(k)) probe_oor_q[k] <= probe_oor;
      end
      if (state == DRAIN && cyc == LAST_DRAIN) result <= stage_next;
    end
  end

  assign terrain_center = result[0];
  assign terrain_xplus  = result[1];
  assign terrain_yplus  = result[2];
  assign terrain_xminus = result[3];
  assign terrain_yminus = result[4];

endmodule

// File: tb/tb_terrain_probe_scheduler.sv
// Bench for terrain_probe_scheduler: directed vector table, reset and held-start
// sequences, and randomized sweeps, on READ_LATENCY=2 and READ_LATENCY=3 builds.
module tb_terrain_probe_scheduler;

  localparam int W   = 160;
  localparam int H   = 90;
  localparam int OFF = 128;

  logic        clk_in = 1'b0;
  logic        rst_in_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bx = '0, by = '0;
  logic [1:0]  salt = '0;
  logic [1:0]  junk = '0;

  always #5 clk_in = ~clk_in;

  terrain_probe_scheduler_if mif2 ();
  terrain_probe_scheduler_if mif3 ();

  logic [4:0][1:0] res2, res3, prev2, prev3;
  logic            busy2, done2, busy3, done3;

  terrain_probe_scheduler #(.READ_LATENCY(2)) dut2 (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .start(start),
    .ball_position_x(bx), .ball_position_y(by), .map(mif2),
    .terrain_center(res2[0]), .terrain_xplus(res2[1]), .terrain_yplus(res2[2]),
    .terrain_xminus(res2[3]), .terrain_yminus(res2[4]),
    .busy(busy2), .done(done2));

  terrain_probe_scheduler #(.READ_LATENCY(3)) dut3 (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .start(start),
    .ball_position_x(bx), .ball_position_y(by), .map(mif3),
    .terrain_center(res3[0]), .terrain_xplus(res3[1]), .terrain_yplus(res3[2]),
    .terrain_xminus(res3[3]), .terrain_yminus(res3[4]),
    .busy(busy3), .done(done3));

  // Map memory: code depends on the address; disabled reads return noise.
  function automatic logic [1:0] mem_code(input logic [15:0] a, input logic [1:0] s);
    return a[1:0] ^ s;
  endfunction

  logic [15:0] pa2 [2];
  logic [15:0] pa3 [3];
  logic        pe2 [2];
  logic        pe3 [3];

  always @(posedge clk_in) begin
    pa2[0] <= mif2.map_addr; pe2[0] <= mif2.map_en;
    pa2[1] <= pa2[0];        pe2[1] <= pe2[0];
    pa3[0] <= mif3.map_addr; pe3[0] <= mif3.map_en;
    pa3[1] <= pa3[0];        pe3[1] <= pe3[0];
    pa3[2] <= pa3[1];        pe3[2] <= pe3[1];
    junk   <= 2'($urandom);
  end

  assign mif2.map_data = pe2[1] ? mem_code(pa2[1], salt) : junk;
  assign mif3.map_data = pe3[2] ? mem_code(pa3[2], salt) : junk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: signed integer probe geometry straight from the probe rules.
  function automatic void model_probe(input int x, input int y, input int k,
                                      output bit ok, output int addr);
    int cx = x;
    int cy = y;
    if (k == 1) cx = x + OFF;
    if (k == 2) cy = y + OFF;
    if (k == 3) cx = x - OFF;
    if (k == 4) cy = y - OFF;
    ok   = (cx >= 0) && (cx < 65536) && (cy >= 0) && (cy < 65536)
        && (cx / 256 < W) && (cy / 256 < H);
    addr = ok ? (cx / 256) + W * (cy / 256) : 0;
  endfunction

  function automatic logic [4:0][1:0] model_sweep(input int x, input int y, input logic [1:0] s);
    logic [4:0][1:0] r;
    bit ok;
    int a;
    for (int k = 0; k < 5; k++) begin
      model_probe(x, y, k, ok, a);
      r[k] = ok ? mem_code(16'(a), s) : 2'd1;
    end
    return r;
  endfunction

  function automatic logic [4:0][1:0] pack5(input int c, input int xp, input int yp,
                                            input int xm, input int ym);
    return {2'(ym), 2'(xm), 2'(yp), 2'(xp), 2'(c)};
  endfunction

  // Caller is at a negedge with both builds idle; start is accepted at the next posedge.
  task automatic sweep(input string nm, input logic [15:0] x, input logic [15:0] y,
                       input logic [4:0][1:0] exp_res);
    bit ok;
    int a;
    int exp_addr [5];
    bit exp_en [5];
    int done_at [2];
    int done_cnt [2];
    bit held_bad [2];
    for (int k = 0; k < 5; k++) begin
      model_probe(int'(x), int'(y), k, ok, a);
      exp_en[k]   = ok;
      exp_addr[k] = a;
    end
    done_at  = '{0, 0};
    done_cnt = '{0, 0};
    held_bad = '{0, 0};
    start = 1'b1; bx = x; by = y;
    @(negedge clk_in);
    start = 1'b0; bx = 16'($urandom); by = 16'($urandom);
    for (int j = 1; j <= 10; j++) begin
      if (j <= 5) begin
        check($sformatf("%s/en2_k%0d", nm, j - 1), 32'(mif2.map_en), 32'(exp_en[j-1]));
        check($sformatf("%s/addr2_k%0d", nm, j - 1), 32'(mif2.map_addr), 32'(exp_addr[j-1]));
        check($sformatf("%s/en3_k%0d", nm, j - 1), 32'(mif3.map_en), 32'(exp_en[j-1]));
        check($sformatf("%s/addr3_k%0d", nm, j - 1), 32'(mif3.map_addr), 32'(exp_addr[j-1]));
      end
      if (j == 1) begin
        check({nm, "/busy2_on"}, 32'(busy2), 32'd1);
        check({nm, "/busy3_on"}, 32'(busy3), 32'd1);
      end
      if (done2) begin
        done_cnt[0]++; done_at[0] = j;
        check({nm, "/res2"}, 32'(res2), 32'(exp_res));
      end else if (done_at[0] == 0 && res2 !== prev2) held_bad[0] = 1'b1;
      if (done3) begin
        done_cnt[1]++; done_at[1] = j;
        check({nm, "/res3"}, 32'(res3), 32'(exp_res));
      end else if (done_at[1] == 0 && res3 !== prev3) held_bad[1] = 1'b1;
      if (j == 10) begin
        check({nm, "/busy2_off"}, 32'(busy2), 32'd0);
        check({nm, "/busy3_off"}, 32'(busy3), 32'd0);
      end
      @(negedge clk_in);
    end
    check({nm, "/done2_cycle"}, 32'(done_at[0]), 32'd8);
    check({nm, "/done3_cycle"}, 32'(done_at[1]), 32'd9);
    check({nm, "/done2_count"}, 32'(done_cnt[0]), 32'd1);
    check({nm, "/done3_count"}, 32'(done_cnt[1]), 32'd1);
    check({nm, "/held2"}, 32'(held_bad[0]), 32'd0);
    check({nm, "/held3"}, 32'(held_bad[1]), 32'd0);
    prev2 = exp_res;
    prev3 = exp_res;
  endtask

  typedef struct {
    logic [15:0]     x;
    logic [15:0]     y;
    logic [1:0]      salt;
    logic [4:0][1:0] res;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dones;
    logic [15:0] rx, ry;

    tbl[0] = '{x: 16'h0A80, y: 16'h0A80, salt: 2'd0, res: pack5(2, 3, 2, 2, 2)};
    tbl[1] = '{x: 16'h0040, y: 16'h5980, salt: 2'd0, res: pack5(0, 0, 1, 1, 0)};
    tbl[2] = '{x: 16'hFFC0, y: 16'h0A80, salt: 2'd0, res: pack5(1, 1, 1, 1, 1)};
    tbl[3] = '{x: 16'h9F80, y: 16'h0A80, salt: 2'd0, res: pack5(3, 1, 3, 3, 3)};
    tbl[4] = '{x: 16'h0A80, y: 16'h0040, salt: 2'd0, res: pack5(2, 3, 2, 2, 1)};
    tbl[5] = '{x: 16'h0A80, y: 16'h0A80, salt: 2'd3, res: pack5(1, 0, 1, 1, 1)};

    #1 rst_in_n = 1'b0;
    #1;
    check("rst/busy2", 32'(busy2), 32'd0);
    check("rst/done2", 32'(done2), 32'd0);
    check("rst/en2", 32'(mif2.map_en), 32'd0);
    check("rst/addr2", 32'(mif2.map_addr), 32'd0);
    check("rst/res2", 32'(res2), 32'd0);
    check("rst/res3", 32'(res3), 32'd0);
    prev2 = '0;
    prev3 = '0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in_n = 1'b1;

    // Directed vectors; the first start lands on the first edge after reset release.
    for (int i = 0; i < 6; i++) begin
      salt = tbl[i].salt;
      sweep($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].res);
    end

    // Asynchronous reset in the middle of a sweep.
    salt = 2'd0;
    start = 1'b1; bx = 16'h0A80; by = 16'h0A80;
    @(negedge clk_in);
    start = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    #7 rst_in_n = 1'b0;
    #1;
    check("abort/res2", 32'(res2), 32'd0);
    check("abort/res3", 32'(res3), 32'd0);
    check("abort/busy2", 32'(busy2), 32'd0);
    check("abort/busy3", 32'(busy3), 32'd0);
    check("abort/en2", 32'(mif2.map_en), 32'd0);
    @(negedge clk_in);
    rst_in_n = 1'b1;
    prev2 = '0;
    prev3 = '0;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      if (done2 || done3 || res2 != '0 || res3 != '0) dones++;
      @(negedge clk_in);
    end
    check("abort/quiet_after", 32'(dones), 32'd0);
    sweep("after_abort", tbl[0].x, tbl[0].y, tbl[0].res);

    // start held high: the RL=2 build re-accepts every 9 cycles.
    start = 1'b1; bx = 16'h0A80; by = 16'h0A80;
    for (int c = 0; c < 27; c++) begin
      check($sformatf("hold/busy_c%0d", c), 32'(busy2), 32'((c % 9) != 0));
      check($sformatf("hold/done_c%0d", c), 32'(done2), 32'((c % 9) == 8));
      @(negedge clk_in);
    end
    start = 1'b0;
    for (int c = 0; c < 12; c++) @(negedge clk_in);
    check("hold/res2", 32'(res2), 32'(tbl[0].res));
    check("hold/res3", 32'(res3), 32'(tbl[0].res));
    prev2 = tbl[0].res;
    prev3 = tbl[0].res;

    // Randomized sweeps biased toward the map edges and the 16-bit wrap points.
    for (int i = 0; i < 40; i++) begin
      salt = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       rx = 16'($urandom);
        1:       rx = 16'($urandom_range(W * 256 - 384, W * 256 + 255));
        2:       rx = 16'($urandom_range(0, 511));
        default: rx = 16'($urandom_range(0, W * 256 - 1));
      endcase
      case ($urandom_range(0, 3))
        0:       ry = 16'($urandom);
        1:       ry = 16'($urandom_range(H * 256 - 384, H * 256 + 255));
        2:       ry = 16'($urandom_range(0, 511));
        default: ry = 16'($urandom_range(0, H * 256 - 1));
      endcase
      sweep($sformatf("rnd%0d", i), rx, ry, model_sweep(int'(rx), int'(ry), salt));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
